// File: rtl/window_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: FSM encoding and
// the position of each tap inside the flattened window word.
package window_3x3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Tap Prc = row r (0 = oldest line), column c (0 = leftmost); index r*3+c.
  localparam int unsigned P00 = 0;
  localparam int unsigned P01 = 1;
  localparam int unsigned P02 = 2;
  localparam int unsigned P10 = 3;
  localparam int unsigned P11 = 4;
  localparam int unsigned P12 = 5;
  localparam int unsigned P20 = 6;
  localparam int unsigned P21 = 7;
  localparam int unsigned P22 = 8;

  localparam int unsigned NUM_TAPS = 9;

endpackage

// File: rtl/window_3x3_line_buf.sv
// One line of pixel storage: synchronous write, asynchronous read, no reset.
module line_buf #(
  parameter int DW   = 8,
  parameter int ADDR = 9
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [ADDR-1:0] i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [2**ADDR];

  // Contents are deliberately left unreset; the window logic never lets stale
  // lines reach the output.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3.sv
// Raster-order pixel stream in, complete 3x3 neighbourhoods out, one window per
// interior pixel, using two line buffers and a 3x3 shift register.
module window_3x3
  import window_3x3_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int ADDR  = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_valid,
  input  logic            i_sof,
  input  logic [DW-1:0]   i_data,
  output logic            o_valid,
  output logic [9*DW-1:0] o_win,
  output logic            o_eof,
  output logic            o_busy
);

  localparam int YW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

  localparam logic [ADDR-1:0] X_LAST = ADDR'(IMG_W - 1);
  localparam logic [ADDR-1:0] X_TWO  = ADDR'(2);
  localparam logic [YW-1:0]   Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0]   Y_ONE  = YW'(1);
  localparam logic [YW-1:0]   Y_TWO  = YW'(2);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR-1:0] r_x;
  logic [YW-1:0]   r_y;
  logic [ADDR-1:0] w_x;
  logic [YW-1:0]   w_y;

  logic w_restart;
  logic w_accept;
  logic w_end_row;
  logic w_last_px;
  logic w_emit;

  logic [DW-1:0] w_lb0;
  logic [DW-1:0] w_lb1;

  logic [NUM_TAPS-1:0][DW-1:0] r_win;
  logic [NUM_TAPS-1:0][DW-1:0] w_win_nxt;
  logic [NUM_TAPS-1:0][DW-1:0] r_out;
  logic                        r_valid;
  logic                        r_eof;

  // A start-of-frame pixel is always taken as (0,0), whatever state we are in.
  assign w_restart = i_valid & i_sof;
  assign w_accept  = w_restart | (i_valid & ((r_state == ST_FILL) | (r_state == ST_RUN)));
  assign w_x       = w_restart ? '0 : r_x;
  assign w_y       = w_restart ? '0 : r_y;
  assign w_end_row = (w_x == X_LAST);
  assign w_last_px = w_end_row & (w_y == Y_LAST);
  assign w_emit    = w_accept & (w_y >= Y_TWO) & (w_x >= X_TWO);

  line_buf #(.DW(DW), .ADDR(ADDR)) u_lb0 (
    .i_clk   (CLK),
    .i_we    (w_accept),
    .i_addr  (w_x),
    .i_wdata (i_data),
    .o_rdata (w_lb0)
  );

  line_buf #(.DW(DW), .ADDR(ADDR)) u_lb1 (
    .i_clk   (CLK),
    .i_we    (w_accept),
    .i_addr  (w_x),
    .i_wdata (w_lb0),
    .o_rdata (w_lb1)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_restart) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_restart) begin
          w_state_nxt = ST_FILL;
        end else if (w_accept & w_end_row & (w_y == Y_ONE)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_restart) begin
          w_state_nxt = ST_FILL;
        end else if (w_accept & w_last_px) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = w_restart ? ST_FILL : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift one column left; the new right column is {pixel, line y-1, line y-2}.
  always_comb begin
    w_win_nxt      = r_win;
    w_win_nxt[P00] = r_win[P01];
    w_win_nxt[P01] = r_win[P02];
    w_win_nxt[P02] = w_lb1;
    w_win_nxt[P10] = r_win[P11];
    w_win_nxt[P11] = r_win[P12];
    w_win_nxt[P12] = w_lb0;
    w_win_nxt[P20] = r_win[P21];
    w_win_nxt[P21] = r_win[P22];
    w_win_nxt[P22] = i_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_end_row) begin
        r_x <= '0;
        r_y <= (w_y == Y_LAST) ? '0 : w_y + YW'(1);
      end else begin
        r_x <= w_x + ADDR'(1);
        r_y <= w_y;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_win <= '0;
    end else if (w_accept) begin
      r_win <= w_win_nxt;
    end
  end

  // The output copy only changes when a full interior window is emitted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_eof   <= w_emit & w_last_px;
      if (w_emit) begin
        r_out <= w_win_nxt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_eof   = r_eof;
  assign o_win   = r_out;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_window_3x3.sv
// Scoreboard bench for window_3x3 on a 4x4 image: each driven interior pixel
// queues its expected window, and the monitor pops one per o_valid.
module tb_window_3x3;

  localparam int DW    = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int ADDR  = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_sof = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic            o_valid;
  logic [9*DW-1:0] o_win;
  logic            o_eof;
  logic            o_busy;

  window_3x3 #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR(ADDR)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_win   (o_win),
    .o_eof   (o_eof),
    .o_busy  (o_busy)
  );

  always #5 CLK = ~CLK;

  int cycleCnt = 0;
  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            eof;
    int              due;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   errCnt = 0;
  int   chkCnt = 0;
  int   eofCnt = 0;
  bit   watchBusy = 1'b0;
  bit   watchIdle = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle; interior pixels of a tracked frame queue their window,
  // which must appear in the cycle after the accepting edge.
  task automatic applyStimulus(input bit v, input bit sof, input logic [DW-1:0] d,
                               input bit track, input int y, input int x, input int base);
    exp_t e;
    i_valid = v;
    i_sof   = sof;
    i_data  = d;
    if (track && v && y >= 2 && x >= 2) begin
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(r*3+c)*DW +: DW] = DW'(base + IMG_W*(y-2+r) + (x-2+c));
      e.eof = (y == IMG_H-1) && (x == IMG_W-1);
      e.due = cycleCnt + 1;
      sbQ.push_back(e);
    end
    @(posedge CLK);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Pixels first..last-1 of a frame with value base+4y+x; idle gap cycles hold
  // i_sof high with i_valid low to check that i_sof is qualified.
  task automatic sendFrame(input int base, input int first, input int last,
                           input bit withSof, input bit gaps);
    for (int p = first; p < last; p++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 0, 0, 0);
      end
      applyStimulus(1'b1, withSof && (p == 0), DW'(base + p), withSof,
                    p / IMG_W, p % IMG_W, base);
    end
  endtask

  always @(negedge CLK) begin
    if (o_eof) eofCnt++;
    if (watchBusy) checkOutput("busyB2B", o_busy, 1);
    if (watchIdle) checkOutput("busyIdle", o_busy, 0);
    if (o_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpValid", 1, 0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("latency", cycleCnt, monE.due);
        checkOutput("win", o_win, monE.win);
        checkOutput("eof", o_eof, monE.eof);
      end
    end else if (o_eof) begin
      checkOutput("eofNoValid", 1, 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    idleCycles(3);
    checkOutput("rstValid", o_valid, 0);
    checkOutput("rstWin", o_win, 0);
    checkOutput("rstEof", o_eof, 0);
    checkOutput("rstBusy", o_busy, 0);
    RST = 1'b1;
    idleCycles(2);

    $display("[TB] continuous frame");
    sendFrame(0, 0, 16, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("eofCnt1", eofCnt, 1);
    checkOutput("busyAfter", o_busy, 0);

    $display("[TB] frame with random gaps");
    sendFrame(0, 0, 16, 1'b1, 1'b1);
    idleCycles(5);

    $display("[TB] pixels without sof");
    watchIdle = 1'b1;
    sendFrame(0, 0, 6, 1'b0, 1'b0);
    idleCycles(3);
    watchIdle = 1'b0;

    $display("[TB] restart at pixel 9");
    sendFrame(100, 0, 9, 1'b1, 1'b0);
    sendFrame(0, 0, 16, 1'b1, 1'b0);
    idleCycles(5);

    $display("[TB] reset mid-frame");
    sendFrame(50, 0, 8, 1'b1, 1'b0);
    RST = 1'b0;
    idleCycles(2);
    checkOutput("midRstValid", o_valid, 0);
    checkOutput("midRstWin", o_win, 0);
    checkOutput("midRstEof", o_eof, 0);
    checkOutput("midRstBusy", o_busy, 0);
    RST = 1'b1;
    idleCycles(2);
    sendFrame(0, 0, 16, 1'b1, 1'b0);
    idleCycles(5);

    $display("[TB] back-to-back frames");
    e0 = eofCnt;
    sendFrame(10, 0, 1, 1'b1, 1'b0);
    watchBusy = 1'b1;
    sendFrame(10, 1, 16, 1'b1, 1'b0);
    sendFrame(20, 0, 16, 1'b1, 1'b0);
    watchBusy = 1'b0;
    idleCycles(5);
    checkOutput("eofCnt2", eofCnt - e0, 2);
    watchIdle = 1'b1;
    idleCycles(3);
    watchIdle = 1'b0;

    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
